// File: rtl/apb_i2c_seq_pkg.sv
// Shared types for the APB-to-I2C sequencer: FSM states, bridge register
// map, the host command bundle and the command legality check.
package apb_i2c_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    localparam logic [31:0] ADDR_TX  = 32'd0;
    localparam logic [31:0] ADDR_RX  = 32'd4;
    localparam logic [31:0] ADDR_CFG = 32'd8;
    localparam logic [31:0] ADDR_TMO = 32'd12;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    // TX, CONFIG and TIMEOUT are write-only; RX is read-only.
    function automatic logic cmd_is_legal(input cmd_t c);
        logic ok;
        ok = 1'b0;
        unique case (1'b1)
            c.write:  ok = (c.addr == ADDR_TX)  ||
                           (c.addr == ADDR_CFG) ||
                           (c.addr == ADDR_TMO);
            default:  ok = (c.addr == ADDR_RX);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/apb_i2c_seq_ctrl_if.sv
// Host command/response handshake plus APB master bus of the sequencer.
// master: the sequencer side. slave: host + bridge side (bench, glue).
//   cmd_*  : host command in (valid/ready)
//   rsp_*  : response out (valid/ready)
//   P*     : APB master signals, INT_RX: bridge RX-empty flag, busy: status
interface apb_i2c_seq_ctrl_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        rsp_auto;

    logic        PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    logic        INT_RX;
    logic        busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout, rsp_auto,
        input  rsp_ready,
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR,
        input  INT_RX,
        output busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout, rsp_auto,
        output rsp_ready,
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR,
        output INT_RX,
        input  busy
    );

endinterface

// File: rtl/apb_i2c_seq_cmd_fifo.sv
// Command FIFO of cmd_t, first-word-fall-through read port.
// Ports: PCLK, PRESET (async, high), push/wr_data, pop/rd_data, full, empty.
module apb_i2c_seq_cmd_fifo
    import apb_i2c_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic push,
    input  cmd_t wr_data,
    input  logic pop,
    output cmd_t rd_data,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    cmd_t        mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push_ok;
    logic        pop_ok;

    // Extra pointer bit separates full from empty when indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/apb_i2c_seq_ctrl.sv
// APB master sequencer for the APB-to-I2C bridge: queues host commands,
// runs each as SETUP/ACCESS with PREADY timeout, returns one response each.
// Ports: PCLK, PRESET (async, active-high), bus (apb_i2c_seq_ctrl_if.master).
// Optional: APB_I2C_SEQ_RX_AUTODRAIN_EN adds round-robin auto reads of RX
// while INT_RX=0; otherwise INT_RX is ignored and rsp_auto is tied low.
module apb_i2c_seq_ctrl
    import apb_i2c_seq_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_i2c_seq_ctrl_if.master  bus
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic          psel_q;
    logic          penable_q;
    logic          pwrite_q;
    logic [31:0]   paddr_q;
    logic [31:0]   pwdata_q;
    logic          rsp_valid_q;
    logic          rsp_err_q;
    logic          rsp_tmo_q;
    logic [31:0]   rsp_rdata_q;
    logic [CW-1:0] wait_cnt;

    cmd_t fifo_in;
    cmd_t head;
    cmd_t sel_cmd;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_pop;
    logic fifo_req;
    logic grant_fifo;
    logic grant_auto;
    logic start;

    assign fifo_in = '{write: bus.cmd_write,
                       addr:  bus.cmd_addr,
                       wdata: bus.cmd_wdata};

    apb_i2c_seq_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .push    (bus.cmd_valid),
        .wr_data (fifo_in),
        .pop     (fifo_pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign fifo_req = !fifo_empty;

`ifdef APB_I2C_SEQ_RX_AUTODRAIN_EN
    logic last_auto_q;
    logic rsp_auto_q;
    logic auto_req;

    // last_auto_q resets to 1 so the FIFO wins the first contention.
    assign auto_req   = !bus.INT_RX;
    assign grant_fifo = fifo_req && (!auto_req || last_auto_q);
    assign grant_auto = auto_req && !grant_fifo;
    assign bus.rsp_auto = rsp_auto_q;
`else
    logic unused_int_rx;

    assign unused_int_rx = bus.INT_RX;
    assign grant_fifo    = fifo_req;
    assign grant_auto    = 1'b0;
    assign bus.rsp_auto  = 1'b0;
`endif

    assign start = (state == S_IDLE) && !rsp_valid_q &&
                   (grant_fifo || grant_auto);
    assign fifo_pop = start && grant_fifo;

    always_comb begin
        sel_cmd = head;
        if (grant_auto) begin
            sel_cmd = '{write: 1'b0, addr: ADDR_RX, wdata: 32'd0};
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state       <= S_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
            rsp_rdata_q <= '0;
            wait_cnt    <= '0;
`ifdef APB_I2C_SEQ_RX_AUTODRAIN_EN
            last_auto_q <= 1'b1;
            rsp_auto_q  <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
`ifdef APB_I2C_SEQ_RX_AUTODRAIN_EN
                        last_auto_q <= grant_auto;
                        rsp_auto_q  <= grant_auto;
`endif
                        if (cmd_is_legal(sel_cmd)) begin
                            state    <= S_SETUP;
                            psel_q   <= 1'b1;
                            pwrite_q <= sel_cmd.write;
                            paddr_q  <= sel_cmd.addr;
                            pwdata_q <= sel_cmd.wdata;
                        end else begin
                            // Rejected without touching the APB bus.
                            state       <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_tmo_q   <= 1'b0;
                            rsp_rdata_q <= '0;
                        end
                    end
                end
                S_SETUP: begin
                    state     <= S_ACCESS;
                    penable_q <= 1'b1;
                    wait_cnt  <= '0;
                end
                S_ACCESS: begin
                    if (bus.PREADY) begin
                        state       <= S_RESP;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= bus.PSLVERR;
                        rsp_tmo_q   <= 1'b0;
                        rsp_rdata_q <= pwrite_q ? 32'd0 : bus.PRDATA;
                    end else if (wait_cnt == TMO_LAST) begin
                        state       <= S_RESP;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_tmo_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = !fifo_full;
    assign bus.PSELx       = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_tmo_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.busy        = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_apb_i2c_seq_ctrl.sv
// Directed self-checking bench for apb_i2c_seq_ctrl.
// Default params: FIFO_DEPTH=4, TIMEOUT_CYCLES=16.
module tb_apb_i2c_seq_ctrl;

    logic PCLK = 1'b0;
    logic PRESET;
    int   errs   = 0;
    int   checks = 0;

    apb_i2c_seq_ctrl_if bif ();

    apb_i2c_seq_ctrl #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bif)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic try_push(input logic w, input logic [31:0] a,
                            input logic [31:0] d, output logic acc);
        bif.cmd_valid = 1'b1;
        bif.cmd_write = w;
        bif.cmd_addr  = a;
        bif.cmd_wdata = d;
        acc = bif.cmd_ready;
        tick();
        bif.cmd_valid = 1'b0;
    endtask

    // Runs until rsp_valid (bounded); raises PREADY on ACCESS cycle ready_at.
    task automatic wait_rsp(input int ready_at, output int acc_cyc,
                            output logic seen_sel);
        acc_cyc  = 0;
        seen_sel = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bif.rsp_valid) break;
            seen_sel |= bif.PSELx;
            if (bif.PENABLE) begin
                acc_cyc++;
                if (acc_cyc == ready_at) bif.PREADY = 1'b1;
            end
            tick();
        end
    endtask

    task automatic ack(input string tag);
        bif.rsp_ready = 1'b1;
        tick();
        chk(tag, bif.rsp_valid, 0);
        bif.rsp_ready = 1'b0;
    endtask

    initial begin
        logic acc;
        int   nacc;
        logic sel;

        PRESET        = 1'b1;
        bif.cmd_valid = 1'b0;
        bif.cmd_write = 1'b0;
        bif.cmd_addr  = '0;
        bif.cmd_wdata = '0;
        bif.rsp_ready = 1'b0;
        bif.PRDATA    = '0;
        bif.PREADY    = 1'b0;
        bif.PSLVERR   = 1'b0;
        bif.INT_RX    = 1'b1;
        tick();
        tick();
        chk("rst_cmd_ready", bif.cmd_ready, 1);
        chk("rst_psel", bif.PSELx, 0);
        chk("rst_penable", bif.PENABLE, 0);
        chk("rst_rsp_valid", bif.rsp_valid, 0);
        chk("rst_busy", bif.busy, 0);
        chk("rst_paddr", bif.PADDR, 0);
        chk("rst_rsp_auto", bif.rsp_auto, 0);
        PRESET = 1'b0;
        tick();

        // Write CONFIG, zero-wait: exact latency.
        bif.PREADY = 1'b1;
        try_push(1'b1, 32'd8, 32'h1234, acc);
        chk("t1_acc", acc, 1);
        chk("t1_k_psel", bif.PSELx, 0);
        chk("t1_k_busy", bif.busy, 1);
        tick();
        chk("t1_setup_psel", bif.PSELx, 1);
        chk("t1_setup_pen", bif.PENABLE, 0);
        chk("t1_paddr", bif.PADDR, 32'd8);
        chk("t1_pwdata", bif.PWDATA, 32'h1234);
        chk("t1_pwrite", bif.PWRITE, 1);
        tick();
        chk("t1_access_psel", bif.PSELx, 1);
        chk("t1_access_pen", bif.PENABLE, 1);
        tick();
        chk("t1_rsp_valid", bif.rsp_valid, 1);
        chk("t1_rsp_err", bif.rsp_err, 0);
        chk("t1_rsp_tmo", bif.rsp_timeout, 0);
        chk("t1_resp_psel", bif.PSELx, 0);
        ack("t1_ack");
        chk("t1_idle_busy", bif.busy, 0);

        // Read RX with three wait states.
        bif.PREADY = 1'b0;
        bif.PRDATA = 32'hA5;
        try_push(1'b0, 32'd4, 32'd0, acc);
        wait_rsp(4, nacc, sel);
        chk("t2_pen_cycles", nacc, 4);
        chk("t2_rsp_valid", bif.rsp_valid, 1);
        chk("t2_rdata", bif.rsp_rdata, 32'hA5);
        chk("t2_err", bif.rsp_err, 0);
        bif.PRDATA = 32'h0;
        tick();
        chk("t2_hold_valid", bif.rsp_valid, 1);
        chk("t2_hold_rdata", bif.rsp_rdata, 32'hA5);
        ack("t2_ack");

        // Read RX that never completes: timeout.
        bif.PREADY = 1'b0;
        bif.PRDATA = 32'hDEAD_BEEF;
        try_push(1'b0, 32'd4, 32'd0, acc);
        wait_rsp(0, nacc, sel);
        chk("t3_pen_cycles", nacc, 16);
        chk("t3_rsp_valid", bif.rsp_valid, 1);
        chk("t3_timeout", bif.rsp_timeout, 1);
        chk("t3_err", bif.rsp_err, 1);
        chk("t3_rdata", bif.rsp_rdata, 0);

        // Engine stalled on pending response: fill FIFO.
        try_push(1'b1, 32'd0, 32'h11, acc);
        chk("t4_acc0", acc, 1);
        try_push(1'b1, 32'd8, 32'h22, acc);
        chk("t4_acc1", acc, 1);
        try_push(1'b1, 32'd12, 32'h33, acc);
        chk("t4_acc2", acc, 1);
        try_push(1'b0, 32'd4, 32'd0, acc);
        chk("t4_acc3", acc, 1);
        chk("t4_cmd_ready", bif.cmd_ready, 0);
        try_push(1'b1, 32'd0, 32'h55, acc);
        chk("t4_acc4", acc, 0);
        chk("t4_still_rsp", bif.rsp_valid, 1);
        ack("t4_ack_tmo");
        bif.PRDATA = 32'h77;
        bif.PREADY = 1'b0;
        wait_rsp(1, nacc, sel);
        chk("t4_d0_addr", bif.PADDR, 32'd0);
        chk("t4_d0_data", bif.PWDATA, 32'h11);
        chk("t4_d0_err", bif.rsp_err, 0);
        ack("t4_d0_ack");
        bif.PREADY = 1'b0;
        wait_rsp(1, nacc, sel);
        chk("t4_d1_addr", bif.PADDR, 32'd8);
        chk("t4_d1_data", bif.PWDATA, 32'h22);
        ack("t4_d1_ack");
        bif.PREADY = 1'b0;
        wait_rsp(1, nacc, sel);
        chk("t4_d2_addr", bif.PADDR, 32'd12);
        chk("t4_d2_data", bif.PWDATA, 32'h33);
        ack("t4_d2_ack");
        bif.PREADY = 1'b0;
        wait_rsp(1, nacc, sel);
        chk("t4_d3_addr", bif.PADDR, 32'd4);
        chk("t4_d3_write", bif.PWRITE, 0);
        chk("t4_d3_rdata", bif.rsp_rdata, 32'h77);
        ack("t4_d3_ack");
        chk("t4_drained_busy", bif.busy, 0);
        chk("t4_drained_ready", bif.cmd_ready, 1);

        // Illegal commands and slave error.
        bif.PREADY = 1'b0;
        try_push(1'b1, 32'd4, 32'h66, acc);
        wait_rsp(1, nacc, sel);
        chk("t5_wr4_sel", sel, 0);
        chk("t5_wr4_valid", bif.rsp_valid, 1);
        chk("t5_wr4_err", bif.rsp_err, 1);
        chk("t5_wr4_tmo", bif.rsp_timeout, 0);
        ack("t5_wr4_ack");
        try_push(1'b0, 32'd20, 32'd0, acc);
        wait_rsp(1, nacc, sel);
        chk("t5_rd20_sel", sel, 0);
        chk("t5_rd20_err", bif.rsp_err, 1);
        chk("t5_rd20_rdata", bif.rsp_rdata, 0);
        chk("t5_rd20_paddr", bif.PADDR, 32'd4);
        ack("t5_rd20_ack");
        bif.PSLVERR = 1'b1;
        bif.PREADY  = 1'b0;
        try_push(1'b1, 32'd0, 32'h99, acc);
        wait_rsp(1, nacc, sel);
        chk("t5_slverr_sel", sel, 1);
        chk("t5_slverr_err", bif.rsp_err, 1);
        chk("t5_slverr_tmo", bif.rsp_timeout, 0);
        ack("t5_slverr_ack");
        bif.PSLVERR = 1'b0;

`ifndef APB_I2C_SEQ_RX_AUTODRAIN_EN
        // INT_RX ignored in this build.
        bif.INT_RX = 1'b0;
        sel = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            sel |= bif.PSELx | bif.rsp_valid;
        end
        chk("t6_no_auto", sel, 0);
        chk("t6_busy", bif.busy, 0);
        bif.PREADY = 1'b0;
        bif.PRDATA = 32'h5A;
        try_push(1'b0, 32'd4, 32'd0, acc);
        wait_rsp(1, nacc, sel);
        chk("t6_rdata", bif.rsp_rdata, 32'h5A);
        chk("t6_rsp_auto", bif.rsp_auto, 0);
        ack("t6_ack");
        bif.INT_RX = 1'b1;
`endif

        // Reset in the middle of ACCESS.
        bif.PREADY = 1'b0;
        try_push(1'b0, 32'd4, 32'd0, acc);
        for (int i = 0; i < 8 && !bif.PENABLE; i++) tick();
        chk("t7_in_access", bif.PENABLE, 1);
        PRESET = 1'b1;
        #1;
        chk("t7_psel", bif.PSELx, 0);
        chk("t7_penable", bif.PENABLE, 0);
        chk("t7_rsp_valid", bif.rsp_valid, 0);
        chk("t7_busy", bif.busy, 0);
        tick();
        PRESET = 1'b0;
        bif.PREADY = 1'b1;
        sel = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            sel |= bif.PSELx | bif.rsp_valid;
        end
        chk("t7_no_rsp", sel, 0);

`ifdef APB_I2C_SEQ_RX_AUTODRAIN_EN
        // Round robin: FIFO first after reset, then auto, alternating.
        bif.PREADY = 1'b0;
        bif.PRDATA = 32'h3C;
        try_push(1'b1, 32'd0, 32'hA1, acc);
        bif.INT_RX = 1'b0;
        try_push(1'b1, 32'd0, 32'hA2, acc);
        wait_rsp(1, nacc, sel);
        chk("t8_r0_data", bif.PWDATA, 32'hA1);
        chk("t8_r0_auto", bif.rsp_auto, 0);
        ack("t8_r0_ack");
        bif.PREADY = 1'b0;
        wait_rsp(1, nacc, sel);
        chk("t8_r1_addr", bif.PADDR, 32'd4);
        chk("t8_r1_write", bif.PWRITE, 0);
        chk("t8_r1_auto", bif.rsp_auto, 1);
        chk("t8_r1_rdata", bif.rsp_rdata, 32'h3C);
        ack("t8_r1_ack");
        bif.PREADY = 1'b0;
        wait_rsp(1, nacc, sel);
        chk("t8_r2_data", bif.PWDATA, 32'hA2);
        chk("t8_r2_addr", bif.PADDR, 32'd0);
        chk("t8_r2_auto", bif.rsp_auto, 0);
        ack("t8_r2_ack");
        bif.PREADY = 1'b0;
        wait_rsp(1, nacc, sel);
        chk("t8_r3_addr", bif.PADDR, 32'd4);
        chk("t8_r3_auto", bif.rsp_auto, 1);
        bif.INT_RX = 1'b1;
        ack("t8_r3_ack");
        tick();
        chk("t8_idle_busy", bif.busy, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
